rip_mem_arbiter: RTL

- Shares the single-ported instruction/data RAM between instruction fetch (IF, read-only) and memory access (MA, read/write).
- One transaction in flight at a time; fixed read latency; MA has priority, with a starvation guard for IF.
- Sits between the core pipeline and the RAM macro.
- Accepts a FLUSH from branch/jump resolution so that squashed fetches return no data.

---
 rtl/rip_mem_pkg.sv | 23 ++
 rtl/rip_mem_arbiter_if.sv | 36 +++
 rtl/rip_mem_arb_prio.sv | 57 +++++
 rtl/rip_mem_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rip_mem_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package rip_mem_pkg;

    localparam int unsigned MAX_LATENCY = 7;

    // Bit positions inside the one-hot grant vector
    localparam int unsigned GNT_IF = 0;
    localparam int unsigned GNT_MA = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MA   = 2'd2
    } owner_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rip_mem_arbiter_if.sv
// Pipeline-side request/response signals plus the RAM macro port.
interface rip_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              FLUSH;
    logic              IF_REQ;
    logic [31:0]       IF_ADDR;
    logic              IF_GNT;
    logic              IF_RVALID;
    logic [31:0]       IF_RDATA;
    logic              MA_REQ;
    logic              MA_WE;
    logic [3:0]        MA_BE;
    logic [31:0]       MA_ADDR;
    logic [31:0]       MA_WDATA;
    logic              MA_GNT;
    logic              MA_RVALID;
    logic [31:0]       MA_RDATA;
    logic              MEM_EN;
    logic [3:0]        MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_WDATA;
    logic [31:0]       MEM_RDATA;

    modport slave (
        input  FLUSH, IF_REQ, IF_ADDR, MA_REQ, MA_WE, MA_BE, MA_ADDR, MA_WDATA, MEM_RDATA,
        output IF_GNT, IF_RVALID, IF_RDATA, MA_GNT, MA_RVALID, MA_RDATA,
               MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
    );

    modport master (
        output FLUSH, IF_REQ, IF_ADDR, MA_REQ, MA_WE, MA_BE, MA_ADDR, MA_WDATA, MEM_RDATA,
        input  IF_GNT, IF_RVALID, IF_RDATA, MA_GNT, MA_RVALID, MA_RDATA,
               MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/rip_mem_arb_prio.sv
// Grant priority: MA first, except a fetch that has waited MAX_WAIT cycles wins.
module rip_mem_arb_prio
    import rip_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_if_req,
    input  logic       i_ma_req,
    input  logic       i_flush,
    input  logic       i_win,
    output logic [1:0] o_gnt_c
);
    localparam int unsigned WCNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_nxt;
    logic              w_if_ok;
    logic              w_starved;

    // One-hot grant for the current window
    always_comb begin
        w_if_ok   = i_if_req & ~i_flush;
        w_starved = (r_wcnt == WCNT_W'(MAX_WAIT));
        o_gnt_c   = '0;
        if (i_win) begin
            if (w_starved && w_if_ok) begin
                o_gnt_c[GNT_IF] = 1'b1;
            end else if (i_ma_req) begin
                o_gnt_c[GNT_MA] = 1'b1;
            end else if (w_if_ok) begin
                o_gnt_c[GNT_IF] = 1'b1;
            end
        end
    end

    // Wait counter: saturating count of un-granted live fetch cycles; a flushed cycle holds it
    always_comb begin
        w_wcnt_nxt = r_wcnt;
        if (o_gnt_c[GNT_IF] || !i_if_req) begin
            w_wcnt_nxt = '0;
        end else if (w_if_ok && !w_starved) begin
            w_wcnt_nxt = r_wcnt + WCNT_W'(1);
        end
    end

    // Wait counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wcnt <= '0;
        end else begin
            r_wcnt <= w_wcnt_nxt;
        end
    end

endmodule

// File: rtl/rip_mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and memory access.
module rip_mem_arbiter
    import rip_mem_pkg::*;
#(
    parameter int unsigned LATENCY  = 1,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned ADDR_W   = 14
) (
    input  logic              CLK,
    input  logic              RST,
    rip_mem_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(MAX_LATENCY + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    owner_t           r_owner;
    owner_t           w_owner_nxt;
    logic             r_kill;
    logic             w_kill_nxt;
    logic             r_ma_we;
    logic             w_ma_we_nxt;
    logic             w_win;
    logic             w_resp;
    logic             w_if_rvalid;
    logic             w_ma_rvalid;
    logic [1:0]       w_gnt;
    mem_req_t         w_sel;
    logic             w_unused_addr;

    // A grant window opens when the previous access is in its response cycle or idle
    assign w_win = (r_cnt <= CNT_W'(1)) && !RST;

    rip_mem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_if_req (bus.IF_REQ),
        .i_ma_req (bus.MA_REQ),
        .i_flush  (bus.FLUSH),
        .i_win    (w_win),
        .o_gnt_c  (w_gnt)
    );

    // Winner's request payload; a fetch never writes
    always_comb begin
        w_sel = '{we: 1'b0, be: 4'b0000, addr: bus.IF_ADDR, wdata: 32'h0};
        if (w_gnt[GNT_MA]) begin
            w_sel = '{we: bus.MA_WE, be: bus.MA_BE, addr: bus.MA_ADDR, wdata: bus.MA_WDATA};
        end
    end

    assign w_unused_addr = ^w_sel.addr;

    // RAM port: driven only in the grant cycle
    always_comb begin
        bus.IF_GNT    = w_gnt[GNT_IF];
        bus.MA_GNT    = w_gnt[GNT_MA];
        bus.MEM_EN    = |w_gnt;
        bus.MEM_WE    = '0;
        bus.MEM_ADDR  = '0;
        bus.MEM_WDATA = '0;
        if (|w_gnt) begin
            bus.MEM_ADDR  = w_sel.addr[ADDR_W+1:2];
            bus.MEM_WDATA = w_sel.wdata;
            if (w_sel.we) begin
                bus.MEM_WE = w_sel.be;
            end
        end
    end

    // Response cycle; a squashed fetch (earlier kill or same-cycle flush) returns nothing
    always_comb begin
        w_resp        = (r_cnt == CNT_W'(1)) && !RST;
        w_if_rvalid   = w_resp && (r_owner == OWN_IF) && !r_kill && !bus.FLUSH;
        w_ma_rvalid   = w_resp && (r_owner == OWN_MA);
        bus.IF_RVALID = w_if_rvalid;
        bus.IF_RDATA  = w_if_rvalid ? bus.MEM_RDATA : 32'h0;
        bus.MA_RVALID = w_ma_rvalid;
        bus.MA_RDATA  = (w_ma_rvalid && !r_ma_we) ? bus.MEM_RDATA : 32'h0;
    end

    // Next transaction state: new grant, countdown, owner release and fetch kill
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_kill_nxt  = r_kill;
        w_ma_we_nxt = r_ma_we;
        if (|w_gnt) begin
            w_cnt_nxt   = CNT_W'(LATENCY);
            w_owner_nxt = w_gnt[GNT_MA] ? OWN_MA : OWN_IF;
            w_kill_nxt  = 1'b0;
            w_ma_we_nxt = w_gnt[GNT_MA] & bus.MA_WE;
        end else begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            if (r_cnt == CNT_W'(1)) begin
                w_owner_nxt = OWN_NONE;
                w_kill_nxt  = 1'b0;
            end else if (bus.FLUSH && (r_owner == OWN_IF) && (r_cnt > CNT_W'(1))) begin
                w_kill_nxt = 1'b1;
            end
        end
    end

    // Transaction state register; reset drops any pending response
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= '0;
            r_owner <= OWN_NONE;
            r_kill  <= 1'b0;
            r_ma_we <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_kill  <= w_kill_nxt;
            r_ma_we <= w_ma_we_nxt;
        end
    end

endmodule
